// File: rtl/lockin_frame_packer.sv
// lockin_frame_packer: averages 2^n lock-in results and streams each averaged snapshot as a byte frame.
// Define LOCKIN_PACKER_CHECKSUM_EN to append an XOR checksum byte (14-byte frame instead of 13).
module lockin_frame_packer #(
  parameter int OUTPUT_WIDTH = 24,
  parameter int AVG_LOG2_MAX = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic signed [OUTPUT_WIDTH-1:0] i_channel,
  input  logic signed [OUTPUT_WIDTH-1:0] q_channel,
  input  logic        [OUTPUT_WIDTH-1:0] magnitude,
  input  logic        [15:0]             phase,
  input  logic                           result_valid,
  input  logic                           locked,
  input  logic        [2:0]              avg_log2,
  output logic        [7:0]              tx_data,
  output logic                           tx_valid,
  input  logic                           tx_ready,
  output logic                           frame_busy,
  output logic        [7:0]              overrun_cnt
);
  localparam int ACC_W = OUTPUT_WIDTH + AVG_LOG2_MAX;
  localparam int CNT_W = (AVG_LOG2_MAX > 0) ? AVG_LOG2_MAX : 1;
`ifdef LOCKIN_PACKER_CHECKSUM_EN
  localparam logic [3:0] LAST_IDX = 4'd13;
`else
  localparam logic [3:0] LAST_IDX = 4'd12;
`endif

  typedef enum logic {IDLE, SEND} state_t;

  function automatic logic [2:0] clamp_n(input logic [2:0] a);
    return (32'(a) > AVG_LOG2_MAX) ? 3'(AVG_LOG2_MAX) : a;
  endfunction

  function automatic logic [OUTPUT_WIDTH-1:0] avg_signed(input logic signed [ACC_W-1:0] s,
                                                         input logic [2:0] n);
    return OUTPUT_WIDTH'(s >>> n);
  endfunction

  function automatic logic [OUTPUT_WIDTH-1:0] avg_unsigned(input logic [ACC_W-1:0] s,
                                                           input logic [2:0] n);
    return OUTPUT_WIDTH'(s >> n);
  endfunction

  state_t                   state_q, state_d;
  logic [3:0]               idx_q, idx_d;
  logic signed [ACC_W-1:0]  acc_i_p0, acc_q_p0, sum_i, sum_q;
  logic [ACC_W-1:0]         acc_m_p0, sum_m;
  logic [CNT_W-1:0]         win_cnt_p0, win_len_m1;
  logic [2:0]               n_win_p0, n_cur;
  logic                     win_last, hs, last_hs, snap_free, snap_load, snap_drop;
  logic                     ovr_q;
  logic [7:0]               flags_p1;
  logic [OUTPUT_WIDTH-1:0]  i_p1, q_p1, m_p1;
  logic [15:0]              ph_p1;
  logic [7:0]               frame_byte;

  // Stage p0: window accumulation; n is latched by the first result of a window
  assign n_cur      = (win_cnt_p0 == '0) ? clamp_n(avg_log2) : n_win_p0;
  assign win_len_m1 = CNT_W'((32'd1 << n_cur) - 32'd1);
  assign win_last   = (win_cnt_p0 == win_len_m1);
  assign sum_i = acc_i_p0 + {{AVG_LOG2_MAX{i_channel[OUTPUT_WIDTH-1]}}, i_channel};
  assign sum_q = acc_q_p0 + {{AVG_LOG2_MAX{q_channel[OUTPUT_WIDTH-1]}}, q_channel};
  assign sum_m = acc_m_p0 + {{AVG_LOG2_MAX{1'b0}}, magnitude};

  assign hs        = tx_valid && tx_ready;
  assign last_hs   = hs && (idx_q == LAST_IDX);
  assign snap_free = (state_q == IDLE) || last_hs;
  assign snap_load = result_valid && win_last && snap_free;
  assign snap_drop = result_valid && win_last && !snap_free;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_i_p0    <= '0;
      acc_q_p0    <= '0;
      acc_m_p0    <= '0;
      win_cnt_p0  <= '0;
      n_win_p0    <= '0;
      ovr_q       <= 1'b0;
      overrun_cnt <= '0;
      flags_p1    <= '0;
      i_p1        <= '0;
      q_p1        <= '0;
      m_p1        <= '0;
      ph_p1       <= '0;
    end else if (result_valid) begin
      if (win_last) begin
        acc_i_p0   <= '0;
        acc_q_p0   <= '0;
        acc_m_p0   <= '0;
        win_cnt_p0 <= '0;
        // Stage p1: snapshot of the averaged window, held for the whole frame
        if (snap_free) begin
          flags_p1 <= {3'b000, n_cur, ovr_q, locked};
          i_p1     <= avg_signed(sum_i, n_cur);
          q_p1     <= avg_signed(sum_q, n_cur);
          m_p1     <= avg_unsigned(sum_m, n_cur);
          ph_p1    <= phase;
          ovr_q    <= 1'b0;
        end else begin
          ovr_q <= 1'b1;
          if (overrun_cnt != 8'hFF) overrun_cnt <= overrun_cnt + 8'd1;
        end
      end else begin
        acc_i_p0   <= sum_i;
        acc_q_p0   <= sum_q;
        acc_m_p0   <= sum_m;
        win_cnt_p0 <= win_cnt_p0 + 1'b1;
        if (win_cnt_p0 == '0) n_win_p0 <= n_cur;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    case (state_q)
      IDLE: begin
        if (snap_load) begin
          state_d = SEND;
          idx_d   = '0;
        end
      end
      SEND: begin
        if (hs) begin
          if (idx_q == LAST_IDX) begin
            state_d = snap_load ? SEND : IDLE;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + 4'd1;
          end
        end
      end
      default: begin
        state_d = IDLE;
        idx_d   = '0;
      end
    endcase
  end

`ifdef LOCKIN_PACKER_CHECKSUM_EN
  logic [7:0] csum;
  assign csum = flags_p1 ^ i_p1[23:16] ^ i_p1[15:8] ^ i_p1[7:0]
              ^ q_p1[23:16] ^ q_p1[15:8] ^ q_p1[7:0]
              ^ m_p1[23:16] ^ m_p1[15:8] ^ m_p1[7:0]
              ^ ph_p1[15:8] ^ ph_p1[7:0];
`endif

  always_comb begin
    frame_byte = 8'h00;
    case (idx_q)
      4'd0:  frame_byte = 8'hA5;
      4'd1:  frame_byte = flags_p1;
      4'd2:  frame_byte = i_p1[23:16];
      4'd3:  frame_byte = i_p1[15:8];
      4'd4:  frame_byte = i_p1[7:0];
      4'd5:  frame_byte = q_p1[23:16];
      4'd6:  frame_byte = q_p1[15:8];
      4'd7:  frame_byte = q_p1[7:0];
      4'd8:  frame_byte = m_p1[23:16];
      4'd9:  frame_byte = m_p1[15:8];
      4'd10: frame_byte = m_p1[7:0];
      4'd11: frame_byte = ph_p1[15:8];
      4'd12: frame_byte = ph_p1[7:0];
`ifdef LOCKIN_PACKER_CHECKSUM_EN
      4'd13: frame_byte = csum;
`endif
      default: frame_byte = 8'h00;
    endcase
  end

  always_comb begin
    tx_valid   = (state_q == SEND);
    frame_busy = (state_q == SEND);
    tx_data    = (state_q == SEND) ? frame_byte : 8'h00;
  end

endmodule
